// File: rtl/risc16_pkg.sv
// Shared types, constants and helpers for the RISC_16 single-step harness.
package risc16_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {StIdle, StStep, StRun, StHalt} state_e;

  // Active-low gfedcba glyphs, index = hex digit (F down to 0 in the literal).
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [15:0] pack_instr(logic [9:0] sw);
    return {sw[9:6], sw[5:2], 6'b000000, sw[1:0]};
  endfunction

  function automatic logic [6:0] seg7(logic [3:0] digit);
    return SEG_GLYPHS[digit];
  endfunction

endpackage

// File: rtl/risc16_step_harness_if.sv
// Processor-side bus: stage ticks and display in, step enable and instruction out.
interface risc16_step_harness_if #(
  parameter int unsigned NUM_STAGES = 5
);
  logic [NUM_STAGES-1:0] tick;
  logic [15:0]           proc_display;
  logic                  proc_step;
  logic [15:0]           instruction;

  modport master (input tick, proc_display, output proc_step, instruction);
  modport slave  (output tick, proc_display, input proc_step, instruction);
endinterface

// File: rtl/key_debounce.sv
// Synchronises a raw active-low key and emits a one-cycle pulse per debounced press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sync1_q, sync2_q, level_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // Only a newly accepted low level counts as a press.
        level_q <= sync2_q;
        cnt_q   <= '0;
        press   <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

endmodule

// File: rtl/risc16_step_harness.sv
// Board-level single-step/run harness: key debounce, instruction FIFO, step FSM, displays.
module risc16_step_harness
  import risc16_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned BUF_DEPTH    = 8,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned RUN_DIV      = 12500000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_step_n,
  input  logic                         key_load_n,
  input  logic [9:0]                   sw,
  input  logic                         run_mode,
  risc16_step_harness_if.master        proc,
  output logic [9:0]                   ledr,
  output logic [6:0]                   hex_stage,
  output logic [6:0]                   hex_count,
  output logic                         overflow,
  output logic                         halted
);
  localparam int unsigned AW   = $clog2(BUF_DEPTH);
  localparam int unsigned DivW = $clog2(RUN_DIV);
  localparam int unsigned StW  = $clog2(NUM_STAGES + 1);
  localparam logic [AW:0]     PtrOne  = (AW + 1)'(1);
  localparam logic [AW:0]     DepthV  = (AW + 1)'(BUF_DEPTH);
  localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);

  logic step_press, load_press;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_step_n),
    .press (step_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_load_n),
    .press (load_press)
  );

  logic [15:0]     mem [BUF_DEPTH];
  logic [AW:0]     wr_q, rd_q, count;
  logic            push_q, push, pop, full, empty, fetch;
  logic            overflow_q, halted_q, step_q, step_go, halt_go;
  logic [15:0]     instr_q;
  logic [DivW-1:0] div_q;
  state_e          state_q;

  assign count = wr_q - rd_q;
  assign full  = (count == DepthV);
  assign empty = (count == '0);
  assign push  = push_q && !full;
  assign fetch = proc.tick[NUM_STAGES-1];
  assign pop   = step_go && fetch && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      push_q <= load_press;
      if (push) wr_q <= wr_q + PtrOne;
      if (pop)  rd_q <= rd_q + PtrOne;
      if (push_q && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= pack_instr(sw);
  end

  // An empty fetch racing a push holds the divider so the new word is fetched next cycle.
  always_comb begin
    step_go = 1'b0;
    halt_go = 1'b0;
    unique case (state_q)
      StIdle: step_go = step_press;
      StRun: begin
        if (run_mode && div_q == DivLast) begin
          if (fetch && empty) halt_go = !push;
          else                step_go = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      step_q   <= 1'b0;
      instr_q  <= NOP_INSTR;
      div_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q <= step_go;
      if (step_go && fetch) instr_q <= empty ? NOP_INSTR : mem[rd_q[AW-1:0]];
      unique case (state_q)
        StIdle: begin
          if (step_press) begin
            state_q <= StStep;
          end else if (run_mode) begin
            state_q <= StRun;
            div_q   <= '0;
          end
        end
        StStep: state_q <= StIdle;
        StRun: begin
          if (!run_mode) begin
            state_q <= StIdle;
            div_q   <= '0;
          end else if (halt_go) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            div_q    <= '0;
          end else if (div_q != DivLast) begin
            div_q <= div_q + DivOne;
          end else if (step_go) begin
            div_q <= '0;
          end
        end
        StHalt: begin
          if (!run_mode) begin
            state_q  <= StIdle;
            halted_q <= 1'b0;
          end else if (push) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            div_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [NUM_STAGES-1:0] tick;
  logic [StW-1:0]        stage;

  always_comb begin
    tick  = proc.tick;
    stage = '0;
    if (tick != '0 && (tick & (tick - NUM_STAGES'(1))) == '0) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (tick[NUM_STAGES-1-k]) stage = StW'(k + 1);
      end
    end
  end

  logic unused_display;
  assign unused_display = ^proc.proc_display[15:10];

  assign proc.proc_step   = step_q;
  assign proc.instruction = instr_q;
  assign ledr             = proc.proc_display[9:0];
  assign hex_stage        = seg7(4'(stage));
  assign hex_count        = seg7(4'(count));
  assign overflow         = overflow_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_risc16_step_harness.sv
// Bench for the step harness: vector table for displays, scoreboard for fetched instructions.
module tb_risc16_step_harness;
  localparam int unsigned NS = 5;
  localparam int unsigned BD = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       key_step_n = 1'b1, key_load_n = 1'b1, run_mode = 1'b0;
  logic [9:0] sw = '0;
  logic [9:0] ledr;
  logic [6:0] hex_stage, hex_count;
  logic       overflow, halted;

  risc16_step_harness_if #(.NUM_STAGES(NS)) proc_bus ();

  risc16_step_harness #(
    .NUM_STAGES(NS), .BUF_DEPTH(BD), .DEBOUNCE_CYC(DB), .RUN_DIV(RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_step_n (key_step_n),
    .key_load_n (key_load_n),
    .sw         (sw),
    .run_mode   (run_mode),
    .proc       (proc_bus),
    .ledr       (ledr),
    .hex_stage  (hex_stage),
    .hex_count  (hex_count),
    .overflow   (overflow),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Processor model: 5-stage tick ring advanced by each step.
  logic [NS-1:0] tick_model, tick_ovr = '0;
  logic          ovr_en = 1'b0;
  logic [15:0]   display = 16'h0000;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_model <= 5'b10000;
    else if (proc_bus.proc_step) tick_model <= {tick_model[0], tick_model[NS-1:1]};
  end
  assign proc_bus.tick         = ovr_en ? tick_ovr : tick_model;
  assign proc_bus.proc_display = display;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0e;
    endcase
  endfunction

  function automatic logic [15:0] pack(input logic [9:0] v);
    return {v[9:6], v[5:2], 6'b000000, v[1:0]};
  endfunction

  logic [15:0] sb[$];
  logic [15:0] exp_instr;
  logic        exp_ovf = 1'b0;
  int          cyc = 0, n_steps = 0, last_step = 0;
  bit          have_last = 0, chk_int = 0, prev_step = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (proc_bus.proc_step) begin
        n_steps++;
        check("no_consecutive_step", prev_step, 0);
        if (chk_int && have_last) check("run_interval", cyc - last_step, RD);
        have_last = 1;
        last_step = cyc;
        if (tick_model[NS-1]) begin
          exp_instr = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
          check("fetch_instr", proc_bus.instruction, exp_instr);
        end
      end
      prev_step = proc_bus.proc_step;
    end else begin
      prev_step = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_step();
    key_step_n = 1'b0; cycles(10);
    key_step_n = 1'b1; cycles(10);
  endtask

  task automatic press_load(input logic [9:0] v);
    sw = v;
    if (sb.size() < BD) sb.push_back(pack(v));
    else exp_ovf = 1'b1;
    key_load_n = 1'b0; cycles(10);
    key_load_n = 1'b1; cycles(10);
  endtask

  typedef struct {
    logic [NS-1:0] tick;
    logic [15:0]   disp;
    int            stage;
    logic [9:0]    led;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [9:0] loads[5];
    vecs[0] = '{tick: 5'b10000, disp: 16'hFFFF, stage: 1, led: 10'h3FF};
    vecs[1] = '{tick: 5'b01000, disp: 16'hA5C3, stage: 2, led: 10'h1C3};
    vecs[2] = '{tick: 5'b00100, disp: 16'h1234, stage: 3, led: 10'h234};
    vecs[3] = '{tick: 5'b00010, disp: 16'h0400, stage: 4, led: 10'h000};
    vecs[4] = '{tick: 5'b00001, disp: 16'h03FF, stage: 5, led: 10'h3FF};
    vecs[5] = '{tick: 5'b00000, disp: 16'h8001, stage: 0, led: 10'h001};
    vecs[6] = '{tick: 5'b11000, disp: 16'h0155, stage: 0, led: 10'h155};
    vecs[7] = '{tick: 5'b10001, disp: 16'hFC00, stage: 0, led: 10'h000};
    loads = '{10'h0C5, 10'h13A, 10'h2F1, 10'h35C, 10'h0AA};

    cycles(2);
    check("rst_proc_step", proc_bus.proc_step, 0);
    check("rst_instruction", proc_bus.instruction, 16'h0000);
    check("rst_hex_count", hex_count, glyph(0));
    check("rst_hex_stage", hex_stage, glyph(1));
    check("rst_overflow", overflow, 0);
    check("rst_halted", halted, 0);
    rst_n = 1'b1;
    cycles(2);

    ovr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tick_ovr = vecs[i].tick;
      display  = vecs[i].disp;
      #1;
      check("vec_hex_stage", hex_stage, glyph(vecs[i].stage));
      check("vec_ledr", ledr, vecs[i].led);
    end
    @(negedge clk);
    ovr_en  = 1'b0;
    display = 16'h0000;

    // Bouncy load key: only the final long low may register.
    sw = 10'b1010011011;
    sb.push_back(pack(sw));
    key_load_n = 1'b1; cycles(2);
    key_load_n = 1'b0; cycles(2);
    key_load_n = 1'b1; cycles(2);
    key_load_n = 1'b0; cycles(12);
    key_load_n = 1'b1; cycles(10);
    check("bounce_count", hex_count, glyph(1));

    for (int i = 0; i < 5; i++) begin
      check("step_stage", hex_stage, glyph(i + 1));
      base = n_steps;
      press_step();
      check("step_pulses", n_steps - base, 1);
    end
    check("step_wrap_stage", hex_stage, glyph(1));
    check("step_instr", proc_bus.instruction, 16'hA603);
    check("step_count", hex_count, glyph(0));

    for (int i = 0; i < 5; i++) press_load(loads[i]);
    check("ovf_count", hex_count, glyph(4));
    check("ovf_flag", overflow, exp_ovf);
    repeat (20) press_step();
    check("ovf_drained", hex_count, glyph(0));
    check("ovf_sticky", overflow, exp_ovf);

    base = n_steps;
    press_step();
    check("empty_step_pulses", n_steps - base, 1);
    check("empty_step_nop", proc_bus.instruction, 16'h0000);
    repeat (4) press_step();

    press_load(10'h111);
    press_load(10'h222);
    base      = n_steps;
    have_last = 0;
    chk_int   = 1;
    run_mode  = 1'b1;
    for (int t = 0; t < 400 && !halted; t++) @(negedge clk);
    chk_int = 0;
    check("run_halted", halted, 1);
    check("run_steps", n_steps - base, 10);
    cycles(30);
    check("halt_no_steps", n_steps - base, 10);
    press_load(10'h333);
    check("resume_halted", halted, 0);
    for (int t = 0; t < 200 && !halted; t++) @(negedge clk);
    check("resume_steps", n_steps - base, 15);
    check("resume_halted_again", halted, 1);
    run_mode = 1'b0;
    cycles(2);
    check("halt_exit", halted, 0);

    press_load(10'h044);
    press_load(10'h155);
    press_load(10'h266);
    run_mode = 1'b1;
    cycles(20);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_proc_step", proc_bus.proc_step, 0);
    check("midrun_instr", proc_bus.instruction, 16'h0000);
    check("midrun_count", hex_count, glyph(0));
    check("midrun_halted", halted, 0);
    check("midrun_stage", hex_stage, glyph(1));
    sb.delete();
    run_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base  = n_steps;
    cycles(30);
    check("post_reset_idle", n_steps - base, 0);
    check("post_reset_count", hex_count, glyph(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
